// File: rtl/fall_detect_pkg.sv
// Shared types and default thresholds for the fall detector.
// Thresholds are squared magnitudes at 16384 LSB/g, so no square root is needed downstream.
package fall_detect_pkg;

    typedef enum logic [2:0] {
        FD_IDLE        = 3'd0,
        FD_FREEFALL    = 3'd1,
        FD_IMPACT_WAIT = 3'd2,
        FD_STILL_CHECK = 3'd3
    } fd_state_e;

    localparam logic [31:0] ONE_G_SQ             = 32'd268_435_456;
    localparam logic [31:0] FF_THRESH_SQ_DEF     = 32'd42_954_916;
    localparam logic [31:0] IMPACT_THRESH_SQ_DEF = 32'd869_719_081;
    localparam logic [31:0] STILL_LO_SQ_DEF      = 32'd171_793_449;
    localparam logic [31:0] STILL_HI_SQ_DEF      = 32'd386_554_921;

    localparam int FF_MIN_SAMPLES_DEF = 8;
    localparam int IMPACT_WINDOW_DEF  = 50;
    localparam int STILL_SAMPLES_DEF  = 100;
    localparam int STILL_TIMEOUT_DEF  = 200;

    // Inclusive band test used for the post-impact stillness check.
    function automatic logic in_band(input logic [31:0] mag,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (mag >= lo) && (mag <= hi);
    endfunction

endpackage

// File: rtl/fall_detect_sample_cnt.sv
// Saturating sample counter; clr+inc together loads 1, clr alone loads 0.
// hit is registered-state only: it flags that the next increment reaches MAX.
module fall_detect_sample_cnt #(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Deriving hit from cnt_q keeps the FSM decode free of combinational loops.
    assign hit = (cnt_q == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fall_detect_fsm.sv
// Free-fall -> impact -> stillness detector on the magnitude-squared sample stream.
// Advances only on mag_valid samples; fall_detected pulses one cycle after the qualifying sample.
module fall_detect_fsm
    import fall_detect_pkg::*;
#(
    parameter logic [31:0] FF_THRESH_SQ     = FF_THRESH_SQ_DEF,
    parameter logic [31:0] IMPACT_THRESH_SQ = IMPACT_THRESH_SQ_DEF,
    parameter logic [31:0] STILL_LO_SQ      = STILL_LO_SQ_DEF,
    parameter logic [31:0] STILL_HI_SQ      = STILL_HI_SQ_DEF,
    parameter int          FF_MIN_SAMPLES   = FF_MIN_SAMPLES_DEF,
    parameter int          IMPACT_WINDOW    = IMPACT_WINDOW_DEF,
    parameter int          STILL_SAMPLES    = STILL_SAMPLES_DEF,
    parameter int          STILL_TIMEOUT    = STILL_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mag_valid,
    input  logic [31:0] mag_sq,
    input  logic        flag_clr,
    output logic        fall_detected,
    output logic        fall_flag,
    output logic [7:0]  fall_count,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE        = FD_IDLE;
    localparam logic [2:0] S_FREEFALL    = FD_FREEFALL;
    localparam logic [2:0] S_IMPACT_WAIT = FD_IMPACT_WAIT;
    localparam logic [2:0] S_STILL_CHECK = FD_STILL_CHECK;

    if (FF_MIN_SAMPLES < 1 || IMPACT_WINDOW < 1 || STILL_SAMPLES < 1 || STILL_TIMEOUT < 1)
    begin : g_bad_min
        $error("fall_detect_fsm: sample-count parameters must be >= 1");
    end
    if (STILL_TIMEOUT < STILL_SAMPLES) begin : g_bad_timeout
        $error("fall_detect_fsm: STILL_TIMEOUT must be >= STILL_SAMPLES");
    end

    logic [2:0] state_q, state_d;
    logic       fall_detected_q, fall_detected_d;
    logic       fall_flag_q, fall_flag_d;
    logic [7:0] fall_count_q, fall_count_d;

    logic is_ff, is_imp, is_still;
    logic alarm;
    logic ff_clr, ff_inc, ff_hit;
    logic win_clr, win_inc, win_hit;
    logic run_clr, run_inc, run_hit;
    logic tot_clr, tot_inc, tot_hit;

    // Strict compares: equality with either threshold does not qualify.
    assign is_ff    = (mag_sq < FF_THRESH_SQ);
    assign is_imp   = (mag_sq > IMPACT_THRESH_SQ);
    assign is_still = in_band(mag_sq, STILL_LO_SQ, STILL_HI_SQ);

    fall_detect_sample_cnt #(.MAX(FF_MIN_SAMPLES)) u_ff_cnt (
        .clk(clk), .rst_n(rst_n), .clr(ff_clr), .inc(ff_inc), .hit(ff_hit)
    );
    fall_detect_sample_cnt #(.MAX(IMPACT_WINDOW)) u_win_cnt (
        .clk(clk), .rst_n(rst_n), .clr(win_clr), .inc(win_inc), .hit(win_hit)
    );
    fall_detect_sample_cnt #(.MAX(STILL_SAMPLES)) u_run_cnt (
        .clk(clk), .rst_n(rst_n), .clr(run_clr), .inc(run_inc), .hit(run_hit)
    );
    fall_detect_sample_cnt #(.MAX(STILL_TIMEOUT)) u_tot_cnt (
        .clk(clk), .rst_n(rst_n), .clr(tot_clr), .inc(tot_inc), .hit(tot_hit)
    );

    // Every exit back to IDLE clears the counters it used, so IDLE always sees them at zero.
    always_comb begin
        state_d = state_q;
        alarm   = 1'b0;
        ff_clr  = 1'b0;
        ff_inc  = 1'b0;
        win_clr = 1'b0;
        win_inc = 1'b0;
        run_clr = 1'b0;
        run_inc = 1'b0;
        tot_clr = 1'b0;
        tot_inc = 1'b0;
        if (mag_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_ff) begin
                        if (ff_hit) begin
                            ff_clr  = 1'b1;
                            win_clr = 1'b1;
                            state_d = S_IMPACT_WAIT;
                        end else begin
                            ff_clr  = 1'b1;
                            ff_inc  = 1'b1;
                            state_d = S_FREEFALL;
                        end
                    end
                end
                S_FREEFALL: begin
                    if (!is_ff) begin
                        ff_clr  = 1'b1;
                        state_d = S_IDLE;
                    end else if (ff_hit) begin
                        ff_clr  = 1'b1;
                        win_clr = 1'b1;
                        state_d = S_IMPACT_WAIT;
                    end else begin
                        ff_inc = 1'b1;
                    end
                end
                S_IMPACT_WAIT: begin
                    if (is_imp) begin
                        win_clr = 1'b1;
                        run_clr = 1'b1;
                        tot_clr = 1'b1;
                        state_d = S_STILL_CHECK;
                    end else if (win_hit) begin
                        win_clr = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        win_inc = 1'b1;
                    end
                end
                S_STILL_CHECK: begin
                    // Completion is tested before timeout so a coincident sample still alarms.
                    if (is_still && run_hit) begin
                        alarm   = 1'b1;
                        run_clr = 1'b1;
                        tot_clr = 1'b1;
                        state_d = S_IDLE;
                    end else if (tot_hit) begin
                        run_clr = 1'b1;
                        tot_clr = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tot_inc = 1'b1;
                        if (is_still) begin
                            run_inc = 1'b1;
                        end else begin
                            run_clr = 1'b1;
                        end
                    end
                end
                default: begin
                    ff_clr  = 1'b1;
                    win_clr = 1'b1;
                    run_clr = 1'b1;
                    tot_clr = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fall_detected_d = alarm;
        fall_flag_d     = fall_flag_q;
        fall_count_d    = fall_count_q;
        if (alarm) begin
            fall_flag_d = 1'b1;
            if (fall_count_q != 8'hFF) begin
                fall_count_d = fall_count_q + 8'd1;
            end
        end else if (flag_clr) begin
            fall_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            fall_detected_q <= 1'b0;
            fall_flag_q     <= 1'b0;
            fall_count_q    <= 8'd0;
        end else begin
            state_q         <= state_d;
            fall_detected_q <= fall_detected_d;
            fall_flag_q     <= fall_flag_d;
            fall_count_q    <= fall_count_d;
        end
    end

    assign fall_detected = fall_detected_q;
    assign fall_flag     = fall_flag_q;
    assign fall_count    = fall_count_q;
    assign state         = state_q;

endmodule

// File: tb/tb_fall_detect_fsm.sv
// Directed bench for fall_detect_fsm with shortened sample counts (3/4/3/6).
module tb_fall_detect_fsm;

    localparam logic [31:0] FF_V   = 32'd10_000_000;
    localparam logic [31:0] IMP_V  = 32'd900_000_000;
    localparam logic [31:0] G1_V   = 32'd268_435_456;
    localparam logic [31:0] OUT_V  = 32'd500_000_000;
    localparam logic [31:0] FF_EQ  = 32'd42_954_916;
    localparam logic [31:0] IMP_EQ = 32'd869_719_081;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mag_valid;
    logic [31:0] mag_sq;
    logic        flag_clr;
    logic        fall_detected;
    logic        fall_flag;
    logic [7:0]  fall_count;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    fall_detect_fsm #(
        .FF_MIN_SAMPLES(3),
        .IMPACT_WINDOW (4),
        .STILL_SAMPLES (3),
        .STILL_TIMEOUT (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mag_valid    (mag_valid),
        .mag_sq       (mag_sq),
        .flag_clr     (flag_clr),
        .fall_detected(fall_detected),
        .fall_flag    (fall_flag),
        .fall_count   (fall_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid sample, then gap idle cycles carrying a free-fall value that must be ignored.
    task automatic send(input logic [31:0] v, input int gap, input logic clr);
        @(negedge clk);
        mag_valid = 1'b1;
        mag_sq    = v;
        flag_clr  = clr;
        @(negedge clk);
        mag_valid = 1'b0;
        flag_clr  = 1'b0;
        mag_sq    = 32'd5;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fall_seq(input int gap);
        repeat (3) send(FF_V, gap, 1'b0);
        send(IMP_V, gap, 1'b0);
        repeat (3) send(G1_V, gap, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mag_valid = 1'b0;
        mag_sq    = 32'd0;
        flag_clr  = 1'b0;
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_det", 32'(fall_detected), 0);
        chk("rst_flag", 32'(fall_flag), 0);
        chk("rst_count", 32'(fall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean fall
        send(FF_V, 0, 1'b0);  chk("s1_ff1", 32'(state), 1);
        send(FF_V, 0, 1'b0);  chk("s1_ff2", 32'(state), 1);
        send(FF_V, 0, 1'b0);  chk("s1_ff3", 32'(state), 2);
        send(IMP_V, 0, 1'b0); chk("s1_imp", 32'(state), 3);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);  chk("s1_st2_state", 32'(state), 3);
        chk("s1_st2_det", 32'(fall_detected), 0);
        send(G1_V, 0, 1'b0);
        chk("s1_det", 32'(fall_detected), 1);
        chk("s1_state", 32'(state), 0);
        chk("s1_flag", 32'(fall_flag), 1);
        chk("s1_count", 32'(fall_count), 1);
        @(negedge clk);
        chk("s1_det_drop", 32'(fall_detected), 0);

        // Short free-fall and threshold equality
        send(FF_V, 0, 1'b0);
        send(FF_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);  chk("s2_short", 32'(state), 0);
        chk("s2_count", 32'(fall_count), 1);
        send(FF_EQ, 0, 1'b0); chk("s2_ff_eq", 32'(state), 0);

        // Impact window expiry
        repeat (3) send(FF_V, 0, 1'b0);
        repeat (3) send(G1_V, 0, 1'b0);
        chk("s3_win3", 32'(state), 2);
        send(G1_V, 0, 1'b0);  chk("s3_expire", 32'(state), 0);
        send(IMP_V, 0, 1'b0); chk("s3_late_imp", 32'(state), 0);
        chk("s3_late_cnt", 32'(fall_count), 1);
        repeat (3) send(FF_V, 0, 1'b0);
        repeat (3) send(G1_V, 0, 1'b0);
        send(IMP_V, 0, 1'b0); chk("s3_imp_last", 32'(state), 3);
        repeat (5) send(OUT_V, 0, 1'b0);
        chk("s3_tot5", 32'(state), 3);
        send(OUT_V, 0, 1'b0); chk("s3_timeout", 32'(state), 0);
        chk("s3_to_cnt", 32'(fall_count), 1);
        repeat (3) send(FF_V, 0, 1'b0);
        send(IMP_EQ, 0, 1'b0); chk("s3_imp_eq", 32'(state), 2);
        repeat (3) send(G1_V, 0, 1'b0);
        chk("s3_imp_eq_exp", 32'(state), 0);

        // Interrupted stillness: completion coincides with timeout
        repeat (3) send(FF_V, 0, 1'b0);
        send(IMP_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(OUT_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);  chk("s4_pre", 32'(state), 3);
        send(G1_V, 0, 1'b0);
        chk("s4_det", 32'(fall_detected), 1);
        chk("s4_state", 32'(state), 0);
        chk("s4_count", 32'(fall_count), 2);
        // Two breaks keep the run short of 3 until the timeout
        repeat (3) send(FF_V, 0, 1'b0);
        send(IMP_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(OUT_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(OUT_V, 0, 1'b0);
        chk("s4b_state", 32'(state), 0);
        chk("s4b_det", 32'(fall_detected), 0);
        send(G1_V, 0, 1'b0);
        chk("s4b_count", 32'(fall_count), 2);

        // Gaps between samples change nothing
        repeat (3) send(FF_V, 5, 1'b0);
        chk("s5_gap_iw", 32'(state), 2);
        send(IMP_V, 5, 1'b0);
        repeat (3) send(G1_V, 5, 1'b0);
        chk("s5_gap_state", 32'(state), 0);
        chk("s5_gap_count", 32'(fall_count), 3);
        chk("s5_gap_flag", 32'(fall_flag), 1);

        // Asynchronous reset during STILL_CHECK
        repeat (3) send(FF_V, 0, 1'b0);
        send(IMP_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        chk("s5_pre_rst", 32'(state), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_arst_state", 32'(state), 0);
        chk("s5_arst_flag", 32'(fall_flag), 0);
        chk("s5_arst_count", 32'(fall_count), 0);
        chk("s5_arst_det", 32'(fall_detected), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        chk("s5_post_rst", 32'(fall_count), 0);

        // Set beats clear in the same cycle; a later clear drops the flag
        repeat (3) send(FF_V, 0, 1'b0);
        send(IMP_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b0);
        send(G1_V, 0, 1'b1);
        chk("s6_set_wins", 32'(fall_flag), 1);
        chk("s6_cnt1", 32'(fall_count), 1);
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("s6_clr", 32'(fall_flag), 0);

        // Saturation at 255
        repeat (254) fall_seq(0);
        chk("s6_cnt255", 32'(fall_count), 255);
        fall_seq(0);
        chk("s6_sat_det", 32'(fall_detected), 1);
        chk("s6_sat", 32'(fall_count), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
